// File: rtl/decodec.sv
// decodec: registered instruction decoder for the two-accumulator 16-bit CPU.
//
// Splits the instruction word into its operand fields and generates the
// datapath controls one clock after the instruction is sampled.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears every output
//   in[15:0]     instruction word, opcode in[15:10]
//   flagA[2:0]   accumulator A flags {N,Z,C}
//   flagB[2:0]   accumulator B flags {N,Z,C}
//   selA/selB    accumulator input mux (00 hold, 01 ALU, 10 mem, 11 imm)
//   selM1        memory write-data source (0 A, 1 B)
//   selM2        ALU second operand (0 other accumulator, 1 memory)
//   wrEnable     data-memory write strobe
//   jmpEnable    unconditional jump taken
//   branchEnable conditional branch taken
//   inm          immediate in[7:0]
//   memDir       data-memory address in[9:0]
//   branchDir    branch target in[5:0]
//   jmpDir       jump target in[9:0]
//   opCode       opcode in[15:10]
//
// Build option:
//   DECODEC_STRICT_NOP_EN  when defined, an undefined opcode registers
//                          opCode and all field outputs as zero.
module decodec (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [2:0]  flagA,
  input  logic [2:0]  flagB,
  output logic [1:0]  selA,
  output logic [1:0]  selB,
  output logic        selM1,
  output logic        selM2,
  output logic        wrEnable,
  output logic        jmpEnable,
  output logic        branchEnable,
  output logic [7:0]  inm,
  output logic [9:0]  memDir,
  output logic [5:0]  branchDir,
  output logic [9:0]  jmpDir,
  output logic [5:0]  opCode
);

  logic [1:0] selA_d, selA_q, selB_d, selB_q;
  logic       selM1_d, selM1_q, selM2_d, selM2_q;
  logic       wr_d, wr_q, jmp_d, jmp_q, br_d, br_q;
  logic [7:0] inm_d, inm_q;
  logic [9:0] memDir_d, memDir_q, jmpDir_d, jmpDir_q;
  logic [5:0] branchDir_d, branchDir_q, opCode_d, opCode_q;
  logic [5:0] opc;
  logic [2:0] flags;

  assign opc = in[15:10];

  always_comb begin
    selA_d      = 2'b00;
    selB_d      = 2'b00;
    selM1_d     = 1'b0;
    selM2_d     = 1'b0;
    wr_d        = 1'b0;
    jmp_d       = 1'b0;
    br_d        = 1'b0;
    flags       = '0;
    inm_d       = in[7:0];
    memDir_d    = in[9:0];
    branchDir_d = in[5:0];
    jmpDir_d    = in[9:0];
    opCode_d    = opc;

    case (opc) inside
      6'h00: ;
      6'h01: selA_d = 2'b10;
      6'h02: selB_d = 2'b10;
      6'h03: selA_d = 2'b11;
      6'h04: selB_d = 2'b11;
      6'h05: wr_d   = 1'b1;
      6'h06: begin
        wr_d    = 1'b1;
        selM1_d = 1'b1;
      end
      [6'h08:6'h0F]: selA_d = 2'b01;
      [6'h10:6'h17]: selB_d = 2'b01;
      [6'h18:6'h1B]: begin
        selA_d  = 2'b01;
        selM2_d = 1'b1;
      end
      [6'h1C:6'h1F]: begin
        selB_d  = 2'b01;
        selM2_d = 1'b1;
      end
      // opc[2] picks the accumulator, opc[1:0] picks the condition.
      [6'h20:6'h27]: begin
        flags = opc[2] ? flagB : flagA;
        case (opc[1:0])
          2'd0:    br_d = flags[1];
          2'd1:    br_d = ~flags[1];
          2'd2:    br_d = flags[2];
          default: br_d = flags[0];
        endcase
      end
      6'h28: jmp_d = 1'b1;
      default: begin
`ifdef DECODEC_STRICT_NOP_EN
        inm_d       = '0;
        memDir_d    = '0;
        branchDir_d = '0;
        jmpDir_d    = '0;
        opCode_d    = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      selA_q      <= '0;
      selB_q      <= '0;
      selM1_q     <= 1'b0;
      selM2_q     <= 1'b0;
      wr_q        <= 1'b0;
      jmp_q       <= 1'b0;
      br_q        <= 1'b0;
      inm_q       <= '0;
      memDir_q    <= '0;
      branchDir_q <= '0;
      jmpDir_q    <= '0;
      opCode_q    <= '0;
    end else begin
      selA_q      <= selA_d;
      selB_q      <= selB_d;
      selM1_q     <= selM1_d;
      selM2_q     <= selM2_d;
      wr_q        <= wr_d;
      jmp_q       <= jmp_d;
      br_q        <= br_d;
      inm_q       <= inm_d;
      memDir_q    <= memDir_d;
      branchDir_q <= branchDir_d;
      jmpDir_q    <= jmpDir_d;
      opCode_q    <= opCode_d;
    end
  end

  assign selA         = selA_q;
  assign selB         = selB_q;
  assign selM1        = selM1_q;
  assign selM2        = selM2_q;
  assign wrEnable     = wr_q;
  assign jmpEnable    = jmp_q;
  assign branchEnable = br_q;
  assign inm          = inm_q;
  assign memDir       = memDir_q;
  assign branchDir    = branchDir_q;
  assign jmpDir       = jmpDir_q;
  assign opCode       = opCode_q;

endmodule

// File: tb/tb_decodec.sv
// Testbench for decodec: directed test-plan cases with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_decodec;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic [2:0]  flagA, flagB;
  logic [1:0]  selA, selB;
  logic        selM1, selM2, wrEnable, jmpEnable, branchEnable;
  logic [7:0]  inm;
  logic [9:0]  memDir, jmpDir;
  logic [5:0]  branchDir, opCode;

  int errors = 0;
  int checks = 0;

  decodec dut (
    .clk(clk), .reset(reset), .in(in), .flagA(flagA), .flagB(flagB),
    .selA(selA), .selB(selB), .selM1(selM1), .selM2(selM2),
    .wrEnable(wrEnable), .jmpEnable(jmpEnable), .branchEnable(branchEnable),
    .inm(inm), .memDir(memDir), .branchDir(branchDir), .jmpDir(jmpDir),
    .opCode(opCode)
  );

  always #5 clk = ~clk;

  // Output bundle: {selA,selB,selM1,selM2,wr,jmp,br,inm,memDir,branchDir,jmpDir,opCode}
  logic [48:0] dut_v;
  assign dut_v = {selA, selB, selM1, selM2, wrEnable, jmpEnable, branchEnable,
                  inm, memDir, branchDir, jmpDir, opCode};

  function automatic logic [48:0] model(input logic [15:0] w,
                                        input logic [2:0] fa,
                                        input logic [2:0] fb);
    int unsigned op;
    logic [1:0] sa, sb;
    logic m1, m2, wr, jmp, br, known;
    logic [2:0] f;
    logic [7:0] im;
    logic [9:0] md, jd;
    logic [5:0] bd, oc;
    op = w[15:10];
    sa = 0; sb = 0; m1 = 0; m2 = 0; wr = 0; jmp = 0; br = 0;
    known = !(op == 7 || op > 40);
    if (op == 1) sa = 2;
    else if (op == 2) sb = 2;
    else if (op == 3) sa = 3;
    else if (op == 4) sb = 3;
    else if (op == 5) wr = 1;
    else if (op == 6) begin wr = 1; m1 = 1; end
    else if (op >= 8 && op < 32) begin
      m2 = (op >= 24);
      if ((op >= 16 && op < 24) || op >= 28) sb = 1; else sa = 1;
    end else if (op >= 32 && op < 40) begin
      f = (op >= 36) ? fb : fa;
      case (op % 4)
        0: br = f[1];
        1: br = !f[1];
        2: br = f[2];
        default: br = f[0];
      endcase
    end else if (op == 40) jmp = 1;
    im = w[7:0]; md = w[9:0]; jd = w[9:0]; bd = w[5:0]; oc = w[15:10];
`ifdef DECODEC_STRICT_NOP_EN
    if (!known) begin im = 0; md = 0; jd = 0; bd = 0; oc = 0; end
`endif
    return {sa, sb, m1, m2, wr, jmp, br, im, md, bd, jd, oc};
  endfunction

  // Expected outputs after each edge, derived from inputs sampled at that edge.
  logic [48:0] exp_q;
  logic        exp_valid = 1'b0;
  always @(posedge clk) begin
    exp_q     <= reset ? '0 : model(in, flagA, flagB);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (dut_v !== exp_q) begin
        errors++;
        $display("FAIL model_cmp t=%0t in=%h act=%h exp=%h", $time, in, dut_v, exp_q);
      end
      if (int'(wrEnable) + int'(jmpEnable) + int'(branchEnable) > 1) begin
        errors++;
        $display("FAIL one_hot_enables t=%0t act=%b%b%b", $time, wrEnable, jmpEnable, branchEnable);
      end
    end
  end

  task automatic lit(input string name, input logic [48:0] act, input logic [48:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] w, input logic [2:0] fa, input logic [2:0] fb);
    reset = r; in = w; flagA = fa; flagB = fb;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in = 16'hA3FF; flagA = 3'b000; flagB = 3'b000;
    @(negedge clk);
    lit("reset_all_zero", dut_v, '0);
    step(1'b0, 16'h0000, 3'b000, 3'b000);
    lit("post_reset_nop", dut_v, '0);
    step(1'b0, 16'h0C55, 3'b000, 3'b000);
    lit("ldca_selA", 49'(selA), 49'(2'b11));
    lit("ldca_inm", 49'(inm), 49'(8'h55));
    lit("ldca_opcode", 49'(opCode), 49'(6'h03));
    lit("ldca_selB_en", 49'({selB, wrEnable, jmpEnable, branchEnable}), '0);
    step(1'b0, 16'h19A3, 3'b000, 3'b000);
    lit("stb_ctrl", 49'({wrEnable, selM1}), 49'(2'b11));
    lit("stb_memdir", 49'(memDir), 49'(10'h1A3));
    lit("stb_opcode", 49'(opCode), 49'(6'h06));
    step(1'b0, 16'h802A, 3'b010, 3'b000);
    lit("baz_taken", 49'({branchEnable, branchDir}), 49'({1'b1, 6'h2A}));
    step(1'b0, 16'h802A, 3'b000, 3'b111);
    lit("baz_not_taken", 49'({branchEnable, branchDir}), 49'({1'b0, 6'h2A}));
    step(1'b0, 16'hA3FF, 3'b000, 3'b000);
    lit("jmp", 49'({jmpEnable, jmpDir}), 49'({1'b1, 10'h3FF}));
    step(1'b1, 16'hA3FF, 3'b000, 3'b000);
    lit("jmp_then_reset", dut_v, '0);
    step(1'b0, 16'hFC12, 3'b111, 3'b111);
    lit("illegal_ctrl", 49'({selA, selB, selM1, selM2, wrEnable, jmpEnable, branchEnable}), '0);
`ifdef DECODEC_STRICT_NOP_EN
    lit("illegal_fields", 49'({opCode, inm}), '0);
`else
    lit("illegal_fields", 49'({opCode, inm}), 49'({6'h3F, 8'h12}));
`endif
    // Pin a model row by hand: 0x1E = memory-operand ALU op to B.
    lit("model_alu_mem_b", model(16'h7800, 3'b0, 3'b0),
        {2'b00, 2'b01, 1'b0, 1'b1, 3'b000, 8'h00, 10'h000, 6'h00, 10'h000, 6'h1E});

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 0) w[15:10] = 6'($urandom_range(0, 41));
      step(($urandom_range(0, 31) == 0), w, 3'($urandom), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
